multi_pattern_pwm: RTL and testbench

Multi-channel pattern PWM generator: the parametrised successor of the single-channel pattern PWM used alongside the UART packet receiver. It drives CH_NUM independent pattern/pulse channels and exposes a register-write port that the UART command decoder drives. Each channel has shadow-buffered timing and pattern registers and a per-channel start phase offset. All channels start synchronously from one start strobe.

---
 rtl/multi_pattern_pwm_if.sv | 13 +
 rtl/multi_pattern_pwm.sv | 173 +++++++++++++++++
 tb/tb_multi_pattern_pwm.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_pattern_pwm_if.sv
// rtl/multi_pattern_pwm_if.sv - configuration write port for multi_pattern_pwm
interface multi_pattern_pwm_if #(
    parameter int CH_NUM    = 4,
    parameter int PAT_WIDTH = 16
);
    logic                      cfg_we;
    logic [$clog2(CH_NUM)-1:0] cfg_ch;
    logic [2:0]                cfg_sel;
    logic [PAT_WIDTH-1:0]      cfg_wdata;

    modport master (output cfg_we, cfg_ch, cfg_sel, cfg_wdata);
    modport slave  (input  cfg_we, cfg_ch, cfg_sel, cfg_wdata);
endinterface

// File: rtl/multi_pattern_pwm.sv
// rtl/multi_pattern_pwm.sv - multi-channel pattern PWM generator
// Each channel plays PAT_WIDTH slots LSB first from a shadow-buffered register set.
module multi_pattern_pwm #(
    parameter int CH_NUM    = 4,
    parameter int PAT_WIDTH = 16,
    parameter int CNT_WIDTH = 8
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst,
    multi_pattern_pwm_if.slave        cfg,
    input  logic [CH_NUM-1:0]         ch_en,
    input  logic                      start,
    input  logic                      stop,
    output logic [CH_NUM-1:0]         pwm_out,
    output logic [CH_NUM-1:0]         busy,
    output logic [CH_NUM-1:0]         done
);
    localparam int BIT_W = $clog2(PAT_WIDTH);
    localparam int CH_W  = $clog2(CH_NUM);
    localparam logic [BIT_W-1:0]     LAST_BIT = BIT_W'(PAT_WIDTH - 1);
    localparam logic [CNT_WIDTH:0]   ONE_S    = (CNT_WIDTH+1)'(1);
    localparam logic [CNT_WIDTH-1:0] ONE_C    = CNT_WIDTH'(1);

    typedef enum logic [1:0] {S_IDLE, S_DELAY, S_HIGH, S_LOW} state_t;

    typedef struct packed {
        logic [CNT_WIDTH-1:0] duty;
        logic [CNT_WIDTH-1:0] gap;
        logic [CNT_WIDTH-1:0] pulse_num;
        logic [PAT_WIDTH-1:0] pattern;
        logic [CNT_WIDTH-1:0] phase;
    } regs_t;

    localparam regs_t REGS_RST = '{
        duty:      ONE_C,
        gap:       ONE_C,
        pulse_num: ONE_C,
        pattern:   '0,
        phase:     '0
    };

    for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
        state_t               state_q, state_d;
        regs_t                shadow_q, shadow_d;
        regs_t                active_q, active_d;
        logic [CNT_WIDTH:0]   slot_cnt_q, slot_cnt_d;
        logic [BIT_W-1:0]     bit_idx_q, bit_idx_d;
        logic [CNT_WIDTH-1:0] rep_cnt_q, rep_cnt_d;
        logic [CNT_WIDTH-1:0] phase_cnt_q, phase_cnt_d;
        logic                 pwm_q, pwm_d;
        logic                 busy_q, busy_d;
        logic                 done_q, done_d;

        logic [CNT_WIDTH:0]   duty_eff;
        logic [CNT_WIDTH:0]   slot_len;
        logic [CNT_WIDTH:0]   slot_next;
        logic [BIT_W-1:0]     bit_next;
        logic [CNT_WIDTH-1:0] rep_next;
        logic                 abort;

        always_comb begin
            state_d     = state_q;
            shadow_d    = shadow_q;
            active_d    = active_q;
            slot_cnt_d  = slot_cnt_q;
            bit_idx_d   = bit_idx_q;
            rep_cnt_d   = rep_cnt_q;
            phase_cnt_d = phase_cnt_q;
            done_d      = 1'b0;

            duty_eff  = (active_q.duty == '0) ? ONE_S : {1'b0, active_q.duty};
            slot_len  = duty_eff + {1'b0, active_q.gap};
            slot_next = slot_cnt_q + ONE_S;
            bit_next  = bit_idx_q + BIT_W'(1);
            rep_next  = rep_cnt_q + ONE_C;
            abort     = stop || ((state_q != S_IDLE) && !ch_en[i]);

            if (cfg.cfg_we && (cfg.cfg_ch == CH_W'(i))) begin
                case (cfg.cfg_sel)
                    3'd0:    shadow_d.duty      = cfg.cfg_wdata[CNT_WIDTH-1:0];
                    3'd1:    shadow_d.gap       = cfg.cfg_wdata[CNT_WIDTH-1:0];
                    3'd2:    shadow_d.pulse_num = cfg.cfg_wdata[CNT_WIDTH-1:0];
                    3'd3:    shadow_d.pattern   = cfg.cfg_wdata;
                    3'd4:    shadow_d.phase     = cfg.cfg_wdata[CNT_WIDTH-1:0];
                    default: ;
                endcase
            end

            // Loads below read shadow_q, so a same-cycle write lands one load later.
            if (abort) begin
                state_d = S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start && ch_en[i]) begin
                            active_d    = shadow_q;
                            rep_cnt_d   = '0;
                            bit_idx_d   = '0;
                            slot_cnt_d  = '0;
                            phase_cnt_d = '0;
                            if (shadow_q.phase != '0)
                                state_d = S_DELAY;
                            else
                                state_d = shadow_q.pattern[0] ? S_HIGH : S_LOW;
                        end
                    end
                    S_DELAY: begin
                        if (phase_cnt_q == active_q.phase - ONE_C)
                            state_d = active_q.pattern[0] ? S_HIGH : S_LOW;
                        else
                            phase_cnt_d = phase_cnt_q + ONE_C;
                    end
                    default: begin
                        if (slot_cnt_q == slot_len - ONE_S) begin
                            slot_cnt_d = '0;
                            if (bit_idx_q == LAST_BIT) begin
                                rep_cnt_d = rep_next;
                                bit_idx_d = '0;
                                if ((active_q.pulse_num != '0) && (rep_next == active_q.pulse_num)) begin
                                    state_d = S_IDLE;
                                    done_d  = 1'b1;
                                end else begin
                                    active_d = shadow_q;
                                    state_d  = shadow_q.pattern[0] ? S_HIGH : S_LOW;
                                end
                            end else begin
                                bit_idx_d = bit_next;
                                state_d   = active_q.pattern[bit_next] ? S_HIGH : S_LOW;
                            end
                        end else begin
                            slot_cnt_d = slot_next;
                            state_d    = (active_q.pattern[bit_idx_q] && (slot_next < duty_eff))
                                         ? S_HIGH : S_LOW;
                        end
                    end
                endcase
            end

            pwm_d  = (state_d == S_HIGH);
            busy_d = (state_d != S_IDLE);
        end

        always_ff @(posedge sys_clk or posedge sys_rst) begin
            if (sys_rst) begin
                state_q     <= S_IDLE;
                shadow_q    <= REGS_RST;
                active_q    <= REGS_RST;
                slot_cnt_q  <= '0;
                bit_idx_q   <= '0;
                rep_cnt_q   <= '0;
                phase_cnt_q <= '0;
                pwm_q       <= 1'b0;
                busy_q      <= 1'b0;
                done_q      <= 1'b0;
            end else begin
                state_q     <= state_d;
                shadow_q    <= shadow_d;
                active_q    <= active_d;
                slot_cnt_q  <= slot_cnt_d;
                bit_idx_q   <= bit_idx_d;
                rep_cnt_q   <= rep_cnt_d;
                phase_cnt_q <= phase_cnt_d;
                pwm_q       <= pwm_d;
                busy_q      <= busy_d;
                done_q      <= done_d;
            end
        end

        assign pwm_out[i] = pwm_q;
        assign busy[i]    = busy_q;
        assign done[i]    = done_q;
    end
endmodule

// File: tb/tb_multi_pattern_pwm.sv
// tb/tb_multi_pattern_pwm.sv - scoreboard bench for multi_pattern_pwm
// The model expands each repetition into a per-cycle waveform queue that a monitor pops.
`timescale 1ns/1ps
module tb_multi_pattern_pwm;
    localparam int CH = 4;
    localparam int PW = 16;
    localparam int CW = 8;

    typedef logic [2:0] samp_t;    // {pwm_out, busy, done}

    logic          sys_clk = 1'b0;
    logic          sys_rst = 1'b1;
    logic [CH-1:0] ch_en   = '0;
    logic          start   = 1'b0;
    logic          stop    = 1'b0;
    logic [CH-1:0] pwm_out, busy, done;

    multi_pattern_pwm_if #(.CH_NUM(CH), .PAT_WIDTH(PW)) cfg_if ();

    multi_pattern_pwm #(.CH_NUM(CH), .PAT_WIDTH(PW), .CNT_WIDTH(CW)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .cfg     (cfg_if),
        .ch_en   (ch_en),
        .start   (start),
        .stop    (stop),
        .pwm_out (pwm_out),
        .busy    (busy),
        .done    (done)
    );

    always #5 sys_clk = ~sys_clk;

    samp_t           exp_q [CH][$];
    int unsigned     sh_duty [CH], sh_gap [CH], sh_pn [CH], sh_phase [CH];
    logic [PW-1:0]   sh_pat [CH];
    bit              cont [CH];
    int unsigned     reps [CH];
    int              n_cmp = 0;
    int              n_bad = 0;

    function automatic void model_reset();
        for (int c = 0; c < CH; c++) begin
            exp_q[c].delete();
            sh_duty[c] = 1; sh_gap[c] = 1; sh_pn[c] = 1; sh_phase[c] = 0; sh_pat[c] = '0;
            cont[c] = 1'b0; reps[c] = 0;
        end
    endfunction

    // One repetition: PW slots of duty+gap cycles, high for the first duty cycles of a 1 bit.
    function automatic void gen_rep(int c);
        int unsigned d;
        logic [PW-1:0] pat;
        d   = (sh_duty[c] == 0) ? 1 : sh_duty[c];
        pat = sh_pat[c];
        for (int b = 0; b < PW; b++)
            for (int unsigned k = 0; k < d + sh_gap[c]; k++)
                exp_q[c].push_back({pat[b] && (k < d), 1'b1, 1'b0});
        reps[c] = (reps[c] + 1) % 256;
        if (sh_pn[c] != 0 && reps[c] == sh_pn[c]) begin
            exp_q[c].push_back(3'b001);
            cont[c] = 1'b0;
        end else begin
            cont[c] = 1'b1;
        end
    endfunction

    initial model_reset();

    always @(negedge sys_clk) begin
        samp_t cur;
        if (sys_rst) begin
            model_reset();
        end else begin
            for (int c = 0; c < CH; c++) begin
                cur = 3'b000;
                if (exp_q[c].size() > 0) cur = exp_q[c].pop_front();
                if (cur[1] && (stop || !ch_en[c])) begin
                    exp_q[c].delete();
                    cont[c] = 1'b0;
                end else if (cur[1] && exp_q[c].size() == 0 && cont[c]) begin
                    gen_rep(c);
                end else if (!cur[1] && start && !stop && ch_en[c]) begin
                    reps[c] = 0;
                    for (int unsigned p = 0; p < sh_phase[c]; p++) exp_q[c].push_back(3'b010);
                    gen_rep(c);
                end
                if (cfg_if.cfg_we && int'(cfg_if.cfg_ch) == c) begin
                    case (cfg_if.cfg_sel)
                        3'd0: sh_duty[c]  = int'(cfg_if.cfg_wdata[CW-1:0]);
                        3'd1: sh_gap[c]   = int'(cfg_if.cfg_wdata[CW-1:0]);
                        3'd2: sh_pn[c]    = int'(cfg_if.cfg_wdata[CW-1:0]);
                        3'd3: sh_pat[c]   = cfg_if.cfg_wdata;
                        3'd4: sh_phase[c] = int'(cfg_if.cfg_wdata[CW-1:0]);
                        default: ;
                    endcase
                end
            end
        end
    end

    always @(posedge sys_clk) begin
        samp_t e, g;
        #1;
        for (int c = 0; c < CH; c++) begin
            e = (exp_q[c].size() > 0) ? exp_q[c][0] : 3'b000;
            g = {pwm_out[c], busy[c], done[c]};
            n_cmp++;
            if (g !== e) begin
                n_bad++;
                $display("FAIL scoreboard ch%0d t=%0t {pwm,busy,done} got=%b exp=%b", c, $time, g, e);
            end
        end
    end

    task automatic check(string name, int got, int expv);
        n_cmp++;
        if (got != expv) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", name, got, expv);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #2;
        start = 1'b0;
        stop  = 1'b0;
        cfg_if.cfg_we = 1'b0;
    endtask

    task automatic wr(int c, int sel, int data);
        cfg_if.cfg_we    = 1'b1;
        cfg_if.cfg_ch    = 2'(c);
        cfg_if.cfg_sel   = 3'(sel);
        cfg_if.cfg_wdata = 16'(data);
        tick();
    endtask

    task automatic cfg_ch(int c, int duty, int gap, int pn, int pat, int phase);
        wr(c, 0, duty); wr(c, 1, gap); wr(c, 2, pn); wr(c, 3, pat); wr(c, 4, phase);
    endtask

    task automatic async_reset();
        #1;
        sys_rst = 1'b1;
        #1;
        check("async_reset_outputs_zero", int'({pwm_out, busy, done}), 0);
        tick(); tick();
        sys_rst = 1'b0;
        tick();
    endtask

    initial begin
        int d0, d1, cnt_a, cnt_b, cnt_c, found;
        logic [15:0] m0, m1;
        cfg_if.cfg_we = 1'b0; cfg_if.cfg_ch = '0; cfg_if.cfg_sel = '0; cfg_if.cfg_wdata = '0;
        tick(); tick();
        check("reset_outputs_zero", int'({pwm_out, busy, done}), 0);
        sys_rst = 1'b0;
        tick();

        // Basic finite run on ch0 and the same run delayed by phase 5 on ch1.
        cfg_ch(0, 2, 1, 1, 16'h0005, 0);
        cfg_ch(1, 2, 1, 1, 16'h0005, 5);
        ch_en = 4'b0011;
        start = 1'b1;
        tick();
        d0 = -1; d1 = -1; m0 = '0; m1 = '0;
        for (int k = 1; k <= 60; k++) begin
            if (done[0]) d0 = k;
            if (done[1]) d1 = k;
            if (k < 16 && pwm_out[0]) m0[k] = 1'b1;
            if (k < 16 && pwm_out[1]) m1[k] = 1'b1;
            tick();
        end
        check("basic_done0_cycle", d0, 49);
        check("phase_done1_cycle", d1, 54);
        check("basic_pwm0_mask", int'(m0), 16'h0186);
        check("phase_pwm1_mask", int'(m1), 16'h30C0);

        // Shadow duty update during the first repetition of an endless run.
        cfg_ch(2, 3, 0, 0, 16'h0001, 0);
        ch_en = 4'b0100;
        start = 1'b1;
        tick();
        cnt_a = 0; cnt_b = 0; cnt_c = 0;
        for (int k = 1; k <= 80; k++) begin
            if (pwm_out[2]) begin
                if (k <= 48) cnt_a++; else if (k <= 64) cnt_b++; else cnt_c++;
            end
            if (k == 2) begin
                cfg_if.cfg_we = 1'b1; cfg_if.cfg_ch = 2'd2; cfg_if.cfg_sel = 3'd0; cfg_if.cfg_wdata = 16'd1;
            end
            tick();
        end
        check("shadow_first_pulse_len", cnt_a, 3);
        check("shadow_second_rep_pulse", cnt_b, 1);
        check("shadow_third_rep_pulse", cnt_c, 1);

        // Stop during a HIGH cycle.
        found = 0;
        for (int k = 0; k < 40 && found == 0; k++) begin
            if (pwm_out[2]) found = 1; else tick();
        end
        check("stop_found_high", found, 1);
        stop = 1'b1;
        tick();
        check("stop_pwm_low", int'(pwm_out[2]), 0);
        check("stop_busy_low", int'(busy[2]), 0);
        repeat (4) tick();

        // start and stop together leave the channel idle.
        ch_en = 4'b0001;
        start = 1'b1; stop = 1'b1;
        tick();
        check("start_stop_idle", int'(busy[0]), 0);
        repeat (3) tick();

        // Clearing ch_en[2] aborts only ch2.
        wr(0, 2, 0);
        ch_en = 4'b0101;
        start = 1'b1;
        tick();
        repeat (20) tick();
        ch_en = 4'b0001;
        tick();
        check("chen_abort_ch2", int'(busy[2]), 0);
        check("chen_keep_ch0", int'(busy[0]), 1);
        repeat (20) tick();
        stop = 1'b1;
        tick();

        // duty=0,gap=0, all ones: continuously high; a start while busy is ignored.
        cfg_ch(3, 0, 0, 2, 16'hFFFF, 0);
        ch_en = 4'b1000;
        start = 1'b1;
        tick();
        cnt_a = 0; d0 = -1;
        for (int k = 1; k <= 40; k++) begin
            if (pwm_out[3]) cnt_a++;
            if (done[3]) d0 = k;
            if (k == 5) start = 1'b1;
            tick();
        end
        check("allones_high_cycles", cnt_a, 32);
        check("allones_done_cycle", d0, 33);

        // Async reset during DELAY, then a clean restart.
        wr(1, 4, 20);
        ch_en = 4'b0010;
        start = 1'b1;
        tick();
        repeat (4) tick();
        check("delay_busy_before_reset", int'(busy[1]), 1);
        async_reset();
        cfg_ch(1, 2, 1, 1, 16'h0005, 3);
        start = 1'b1;
        tick();
        d1 = -1;
        for (int k = 1; k <= 60; k++) begin
            if (done[1]) d1 = k;
            tick();
        end
        check("restart_after_delay_reset", d1, 52);

        // Async reset during HIGH.
        cfg_ch(0, 4, 0, 0, 16'hFFFF, 0);
        ch_en = 4'b0001;
        start = 1'b1;
        tick();
        repeat (2) tick();
        check("high_before_reset", int'(pwm_out[0]), 1);
        async_reset();
        cfg_ch(0, 4, 0, 0, 16'hFFFF, 0);
        start = 1'b1;
        tick();
        check("restart_after_high_reset", int'(pwm_out[0]), 1);
        repeat (20) tick();
        stop = 1'b1;
        tick();

        // Randomized traffic against the waveform model.
        ch_en = '1;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                int sel;
                int data;
                sel = int'($urandom_range(0, 7));
                case (sel)
                    0, 1:    data = int'($urandom_range(0, 3));
                    2:       data = int'($urandom_range(0, 2));
                    4:       data = int'($urandom_range(0, 6));
                    default: data = int'($urandom_range(0, 16'hFFFF));
                endcase
                cfg_if.cfg_we = 1'b1; cfg_if.cfg_ch = 2'($urandom_range(0, 3));
                cfg_if.cfg_sel = 3'(sel); cfg_if.cfg_wdata = 16'(data);
            end
            if ($urandom_range(0, 29) == 0) start = 1'b1;
            if ($urandom_range(0, 299) == 0) stop = 1'b1;
            if ($urandom_range(0, 149) == 0) ch_en = 4'($urandom_range(0, 15));
            tick();
        end
        stop = 1'b1;
        tick();
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
